// File: rtl/w450_pkg.sv
// w450_pkg: shared data width and MMIO address map for the w450 write decoder
package w450_pkg;
    localparam int N = 8;
    localparam logic [7:0] IO_BASE = 8'hF0;
    localparam logic [7:0] IO_HALT = 8'hFF;
    localparam logic [7:0] IO_TX = 8'hFE;
    localparam logic [7:0] IO_OVF_CLR = 8'hFD;
    localparam int FIFO_AW = 2;
endpackage

// File: rtl/mmio_fifo.sv
// mmio_fifo: first-word-fall-through sync FIFO whose head byte is registered so it holds after draining
module mmio_fifo #(
    parameter int W = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);
    localparam int DEPTH = 1 << AW;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nx;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  head_q, head_d;
    logic          empty, pop, push_ok;
    assign empty   = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign pop     = pop_i & ~empty;
    assign push_ok = push_i & (~full_o | pop);
    assign rd_nx   = rd_q + AW'(1);
    assign data_o  = head_q;
    assign count_o = cnt_q;
    // next pointers, occupancy and head; head refills from the pushed byte when the queue runs dry
    always_comb begin
        wr_d   = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_nx : rd_q;
        cnt_d  = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        head_d = (empty | (pop & cnt_q == (AW+1)'(1))) ? (push_ok ? data_i : head_q)
               : pop ? mem_q[rd_nx] : head_q;
    end
    // storage and pointer registers, all cleared on reset so queued bytes are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (push_ok) mem_q[wr_q] <= data_i;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end
endmodule

// File: rtl/mmio_wr.sv
// mmio_wr: w450 write-port decoder; passes RAM writes to mem, intercepts the I/O window
// (console FIFO, halt, overflow clear). Define MMIO_CYCLE_CNT_EN to build the run-length counter.
module mmio_wr #(
    parameter int N = w450_pkg::N,
    parameter logic [N-1:0] IO_BASE = N'(w450_pkg::IO_BASE),
    parameter int FIFO_AW = w450_pkg::FIFO_AW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] cpu_wr_data,
    input  logic [N-1:0] cpu_wr_addr,
    input  logic         cpu_wr_en,
    output logic [N-1:0] mem_wr_data,
    output logic [N-1:0] mem_wr_addr,
    output logic         mem_wr_en,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         halt,
    output logic [N-1:0] halt_code,
    output logic [7:0]   ovf_cnt,
    output logic [15:0]  cycle_cnt
);
    import w450_pkg::*;
    logic         halt_q, halt_d, io_wr, halt_set, push, ovf_clr, drop, full;
    logic [N-1:0] code_q, code_d;
    logic [7:0]   ovf_q, ovf_d;
    logic [FIFO_AW:0] count;
    assign mem_wr_data = cpu_wr_data;
    assign mem_wr_addr = cpu_wr_addr;
    assign mem_wr_en   = cpu_wr_en & (cpu_wr_addr < IO_BASE) & ~halt_q;
    assign out_valid   = count != '0;
    assign halt        = halt_q;
    assign halt_code   = code_q;
    assign ovf_cnt     = ovf_q;
    // I/O window decode; a halted core can no longer touch any I/O register
    always_comb begin
        io_wr    = cpu_wr_en & (cpu_wr_addr >= IO_BASE) & ~halt_q;
        halt_set = io_wr & (cpu_wr_addr == N'(IO_HALT)) & (cpu_wr_data != '0);
        push     = io_wr & (cpu_wr_addr == N'(IO_TX));
        ovf_clr  = io_wr & (cpu_wr_addr == N'(IO_OVF_CLR));
        drop     = push & full & ~out_ready;
        halt_d   = halt_q | halt_set;
        code_d   = halt_set ? cpu_wr_data : code_q;
        ovf_d    = ovf_clr ? 8'd0 : (drop & ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    end
    // halt flag, exit code and overflow counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_q <= 1'b0;
            code_q <= '0;
            ovf_q  <= '0;
        end else begin
            halt_q <= halt_d;
            code_q <= code_d;
            ovf_q  <= ovf_d;
        end
    end
    mmio_fifo #(.W(N), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (out_ready),
        .data_i  (cpu_wr_data),
        .data_o  (out_data),
        .full_o  (full),
        .count_o (count)
    );
`ifdef MMIO_CYCLE_CNT_EN
    logic [15:0] cyc_q, cyc_d;
    // cycles since reset release, frozen once halted and saturating at all-ones
    always_comb cyc_d = (~halt_q & cyc_q != 16'hFFFF) ? cyc_q + 16'd1 : cyc_q;
    // run-length counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else cyc_q <= cyc_d;
    end
    assign cycle_cnt = cyc_q;
`else
    assign cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_mmio_wr.sv
// tb_mmio_wr: table vectors, hand-written corner sequences and random traffic against a queue model
module tb_mmio_wr;
    logic       clk, rst_n, cpu_wr_en, out_ready;
    logic [7:0] cpu_wr_data, cpu_wr_addr;
    logic [7:0] mem_wr_data, mem_wr_addr, out_data, halt_code, ovf_cnt;
    logic       mem_wr_en, out_valid, halt;
    logic [15:0] cycle_cnt;
    int pass_cnt = 0;
    int total = 0;
    logic [7:0] m_q[$];
    logic       m_halt;
    logic [7:0] m_code, m_shown;
    int         m_ovf, m_cyc;

    mmio_wr dut (
        .clk(clk), .reset(rst_n),
        .cpu_wr_data(cpu_wr_data), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_en(cpu_wr_en),
        .mem_wr_data(mem_wr_data), .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halt(halt), .halt_code(halt_code), .ovf_cnt(ovf_cnt), .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic int exp_cyc();
`ifdef MMIO_CYCLE_CNT_EN
        return m_cyc;
`else
        return 0;
`endif
    endfunction

    function void model_clear();
        m_q.delete();
        m_halt = 0; m_code = 0; m_shown = 0; m_ovf = 0; m_cyc = 0;
    endfunction

    function void model_edge(input logic en, input logic [7:0] a, input logic [7:0] d, input logic r);
        logic io;
        io = en && a >= 8'hF0 && !m_halt;
        if (!m_halt && m_cyc < 65535) m_cyc++;
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (io && a == 8'hFE) begin
            if (m_q.size() < 4) m_q.push_back(d);
            else if (m_ovf < 255) m_ovf++;
        end
        if (io && a == 8'hFD) m_ovf = 0;
        if (io && a == 8'hFF && d != 0) begin m_halt = 1; m_code = d; end
        if (m_q.size() > 0) m_shown = m_q[0];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " out_valid"}, out_valid, m_q.size() > 0);
        chk({tag, " out_data"}, out_data, m_shown);
        chk({tag, " halt"}, halt, m_halt);
        chk({tag, " halt_code"}, halt_code, m_code);
        chk({tag, " ovf_cnt"}, ovf_cnt, m_ovf);
        chk({tag, " cycle_cnt"}, cycle_cnt, exp_cyc());
    endtask

    task automatic cyc(input logic en, input logic [7:0] a, input logic [7:0] d, input logic r);
        cpu_wr_en = en; cpu_wr_addr = a; cpu_wr_data = d; out_ready = r;
        #1;
        chk("mem_wr_en", mem_wr_en, en && a < 8'hF0 && !m_halt);
        chk("mem_wr_addr", mem_wr_addr, a);
        chk("mem_wr_data", mem_wr_data, d);
        @(posedge clk);
        model_edge(en, a, d, r);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; cpu_wr_en = 0; cpu_wr_addr = 0; cpu_wr_data = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_clear();
        check_all("reset");
    endtask

    typedef struct {
        logic en; logic [7:0] a; logic [7:0] d; logic r;
        logic v; logic [7:0] od; logic h; logic [7:0] hc; logic [7:0] ovf;
    } vec_t;
    vec_t tbl[$];

    initial begin
        tbl.push_back('{1'b1, 8'h40, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hF3, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'h43, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h43, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h43, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'hA2, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'hA3, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'hA4, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'hA5, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 8'd1});
        tbl.push_back('{1'b1, 8'hFE, 8'hA6, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 8'd2});
        tbl.push_back('{1'b1, 8'hFD, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'hB7, 1'b1, 1'b1, 8'hA2, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hA2, 1'b0, 8'h00, 8'd0});
        tbl.push_back('{1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 8'hA2, 1'b1, 8'h01, 8'd0});
        tbl.push_back('{1'b1, 8'h10, 8'h33, 1'b1, 1'b1, 8'hA3, 1'b1, 8'h01, 8'd0});
        tbl.push_back('{1'b1, 8'hFE, 8'h99, 1'b1, 1'b1, 8'hA4, 1'b1, 8'h01, 8'd0});
        tbl.push_back('{1'b1, 8'hFF, 8'h77, 1'b1, 1'b1, 8'hB7, 1'b1, 8'h01, 8'd0});
        tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hB7, 1'b1, 8'h01, 8'd0});

        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].en, tbl[i].a, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].v);
            chk($sformatf("vec%0d out_data", i), out_data, tbl[i].od);
            chk($sformatf("vec%0d halt", i), halt, tbl[i].h);
            chk($sformatf("vec%0d halt_code", i), halt_code, tbl[i].hc);
            chk($sformatf("vec%0d ovf_cnt", i), ovf_cnt, tbl[i].ovf);
        end

        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 8'hFE, 8'(8'h20 + i), 0);
        cyc(1, 8'hFF, 8'h05, 0);
        cyc(0, 8'h00, 8'h00, 1);
        cyc(0, 8'h00, 8'h00, 1);
        check_all("pre-async");
        #2 rst_n = 0;
        #1;
        chk("async out_valid", out_valid, 0);
        chk("async halt", halt, 0);
        chk("async ovf_cnt", ovf_cnt, 0);
        chk("async halt_code", halt_code, 0);
        chk("async out_data", out_data, 0);

        do_reset();
        for (int i = 0; i < 260; i++) cyc(1, 8'hFE, 8'(i), 0);
        chk("ovf saturate", ovf_cnt, 255);
        cyc(1, 8'hFD, 8'h00, 0);
        chk("ovf clear", ovf_cnt, 0);

        do_reset();
        repeat (99) cyc(0, 8'h00, 8'h00, 0);
        cyc(1, 8'hFF, 8'h2A, 0);
`ifdef MMIO_CYCLE_CNT_EN
        chk("cycle_cnt at halt", cycle_cnt, 100);
`else
        chk("cycle_cnt at halt", cycle_cnt, 0);
`endif
        repeat (5) cyc(0, 8'h00, 8'h00, 0);
        check_all("cycle frozen");

        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] a, d;
            int sel;
            sel = $urandom_range(0, 9);
            a = sel < 3 ? 8'($urandom_range(0, 8'hEF)) : sel < 4 ? 8'($urandom_range(8'hF0, 8'hFC))
              : sel < 5 ? 8'hFD : sel < 9 ? 8'hFE : 8'hFF;
            d = 8'($urandom);
            if (a == 8'hFF && $urandom_range(0, 15) != 0) d = 8'h00;
            cyc(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 2) == 0));
            check_all("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mmio_wr.md
Name: mmio_wr

Overview:
- Memory-mapped I/O write decoder between the w450 core's single write port and mem.
- Non-I/O writes pass straight through to mem.
- Writes into the I/O window are intercepted:
  - 0xFE pushes a byte into a small output FIFO, drained by a ready/valid consumer.
  - 0xFF latches a sticky halt with an exit code.
  - 0xFD clears the overflow counter.
- Gives benches and the top level a clean halt/console mechanism instead of snooping the raw write bus.

Parameters:
N, 8, data/address width
IO_BASE, 8'hF0, lowest address of the I/O window (IO_BASE..2^N-1 never reach mem)
FIFO_AW, 2, log2 of output FIFO depth (depth 4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
cpu_wr_data  in  N  write data from w450
cpu_wr_addr  in  N  write address from w450
cpu_wr_en  in  1  write strobe from w450
mem_wr_data  out  N  write data to mem
mem_wr_addr  out  N  write address to mem
mem_wr_en  out  1  write strobe to mem
out_data  out  N  FIFO head byte
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head this cycle
halt  out  1  sticky halt flag
halt_code  out  N  data value written to 0xFF
ovf_cnt  out  8  saturating count of dropped pushes
cycle_cnt  out  16  cycles from reset release to halt (see optional feature)

Behaviour:
- Reset (async assert, sync release): FIFO empty, out_valid=0, out_data=0, halt=0, halt_code=0, ovf_cnt=0, cycle_cnt=0.
- Passthrough (combinational, zero latency):
  - mem_wr_data=cpu_wr_data and mem_wr_addr=cpu_wr_addr always.
  - mem_wr_en = cpu_wr_en & (cpu_wr_addr < IO_BASE) & ~halt.
- I/O decode: registered on the clk rising edge, effective only when cpu_wr_en=1, addr>=IO_BASE and halt=0.
  - 0xFF: if data!=0, halt<=1 and halt_code<=data. Data 0 is ignored.
  - 0xFE: push data into the FIFO.
  - 0xFD: ovf_cnt<=0.
  - IO_BASE..0xFC: swallowed, no effect.
- FIFO: depth 2^FIFO_AW, first-word-fall-through.
  - out_data = head entry; out_valid = count!=0.
  - Pop when out_valid & out_ready.
  - Push is accepted when count<depth, or when full and a pop occurs in the same cycle (count unchanged, data written to the freed slot).
  - A push to a full FIFO with no pop is dropped; ovf_cnt increments and saturates at 255.
  - A 0xFD clear and an overflow in the same cycle cannot coincide (single write port).
  - Pointers wrap modulo depth; count is FIFO_AW+1 bits.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_data holds its last value when empty; it does not re-zero.
- Halt:
  - Sticky until reset.
  - Blocks all further mem and I/O writes from the first cycle after the halting edge.
  - The FIFO keeps draining after halt.
  - The halting write itself does not reach mem.
- Reset mid-operation: asynchronous clear of all state, including the FIFO contents; in-flight bytes are lost.

Optional Feature:
MMIO_CYCLE_CNT_EN
- Defined: cycle_cnt increments every clock while reset=1 and halt=0, frozen from the cycle halt rises, saturating at 16'hFFFF.
- Undefined: cycle_cnt tied to 0; no counter flops.

Decomposition:
- Package w450_pkg:
  - N default
  - IO_BASE
  - address constants IO_HALT=8'hFF, IO_TX=8'hFE, IO_OVF_CLR=8'hFD
- Sub-module mmio_fifo: parameterised sync FIFO with push/pop/full/empty/count, async active-low reset.
- mmio_wr holds the decode, halt logic and counters.

Test Plan:
- Write 0x12 to 0x40 -> mem_wr_en=1, mem_wr_addr=0x40, mem_wr_data=0x12 same cycle. Write to 0xF3 -> mem_wr_en=0, no state change.
- Push 0x41,0x42,0x43 to 0xFE with out_ready=0 -> out_valid=1, out_data=0x41 held. Raise out_ready -> 0x41,0x42,0x43 on consecutive cycles, then out_valid=0.
- Push 6 bytes with out_ready=0 (depth 4) -> first 4 retained, ovf_cnt=2. Write 0xFD -> ovf_cnt=0. Full FIFO with push and pop in the same cycle -> count stays 4, ovf_cnt unchanged.
- Write 0x00 to 0xFF -> halt=0. Write 0x01 to 0xFF -> next cycle halt=1, halt_code=0x01. Subsequent write to 0x10 -> mem_wr_en=0. Remaining FIFO bytes still drain.
- Assert reset=0 asynchronously mid-drain with 2 bytes queued -> out_valid=0, halt=0, ovf_cnt=0 immediately, without waiting for a clk edge.
- With MMIO_CYCLE_CNT_EN: release reset, halt after 100 cycles -> cycle_cnt=100, then frozen. Without the macro: cycle_cnt=0 throughout.
